mat_mul_sched: RTL and testbench

MAT_MUL_SCHED -- requirements
Module: mat_mul_sched

---
 rtl/mat_mul_pkg.sv | 14 +
 rtl/mm_track_pipe.sv | 79 +++++++
 rtl/mat_mul_sched.sv | 89 ++++++++
 tb/tb_mat_mul_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mul_pkg.sv
// Shared types and helpers for the mat_mul scheduler and its result tracker.
package mat_mul_pkg;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_ADD = 1'b1
  } mode_t;

  // Multiply latency of an N x N mat_mul: adder-tree depth plus the product stage.
  function automatic int mul_lat(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mm_track_pipe.sv
// Valid/mode/tag shadow of the mat_mul pipeline. Multiplies enter at stage 0,
// adds are injected straight into the output slot; everything moves only on en.
module mm_track_pipe
  import mat_mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             push_valid,
  input  logic             push_mode,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             byp_valid,
  input  logic             byp_mode,
  input  logic [TAG_W-1:0] byp_tag,
  output logic             near_valid,
  output logic             out_valid,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] vld_q, vld_d;
  mode_t            mode_q [DEPTH];
  mode_t            mode_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    vld_d  = vld_q;
    mode_d = mode_q;
    tag_d  = tag_q;
    vld_d[0]  = push_valid;
    mode_d[0] = mode_t'(push_mode);
    tag_d[0]  = push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      mode_d[i] = mode_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
    if (byp_valid) begin
      vld_d[DEPTH-1]  = 1'b1;
      mode_d[DEPTH-1] = mode_t'(byp_mode);
      tag_d[DEPTH-1]  = byp_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
    end
  end

  // NOTE: payload arrays carry no reset; the valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (en) begin
      mode_q <= mode_d;
      tag_q  <= tag_d;
    end
  end

  // The stage feeding the output slot; an add landing now would collide with it.
  generate
    if (DEPTH > 1) begin : g_near
      assign near_valid = vld_q[DEPTH-2];
    end else begin : g_no_near
      assign near_valid = 1'b0;
    end
  endgenerate

  assign out_valid = vld_q[DEPTH-1];
  assign out_mode  = mode_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/mat_mul_sched.sv
// Command scheduler for mat_mul: accepts mul/add commands, stalls adds that would
// collide with a finishing multiply, applies result backpressure via mm_cen.
module mat_mul_sched
  import mat_mul_pkg::*;
#(
  parameter int N       = 8,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = mul_lat(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             mm_cen,
  output logic             mm_valid_in,
  output logic             mm_mode,
  input  logic             mm_valid_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_mode,
  output logic             idle,
  output logic             err
);

  localparam int CW = $clog2(MUL_LAT + 2);

  logic          fire;
  logic          consume;
  logic          is_add;
  logic          near_valid;
  logic [CW-1:0] count_q;
  logic          err_q;

  assign is_add  = (mode_t'(cmd_mode) == MODE_ADD);
  assign mm_cen  = ~(res_valid & ~res_ready);
  assign consume = res_valid & res_ready;

  // Readiness depends only on state and cmd_mode, never on cmd_valid.
  assign cmd_ready   = rstn & mm_cen & ~(is_add & near_valid);
  assign fire        = cmd_valid & cmd_ready;
  assign mm_valid_in = fire;
  assign mm_mode     = cmd_mode;

  mm_track_pipe #(
    .DEPTH (MUL_LAT),
    .TAG_W (TAG_W)
  ) u_track (
    .clk        (clk),
    .rstn       (rstn),
    .en         (mm_cen),
    .push_valid (fire & ~is_add),
    .push_mode  (cmd_mode),
    .push_tag   (cmd_tag),
    .byp_valid  (fire & is_add),
    .byp_mode   (cmd_mode),
    .byp_tag    (cmd_tag),
    .near_valid (near_valid),
    .out_valid  (res_valid),
    .out_mode   (res_mode),
    .out_tag    (res_tag)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      case ({fire, consume})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (mm_valid_out != res_valid) begin
      err_q <= 1'b1;
    end
  end

  assign idle = (count_q == '0);
  assign err  = err_q;

endmodule

// File: tb/tb_mat_mul_sched.sv
// Directed bench for mat_mul_sched with N=8 (MUL_LAT=4) and a mat_mul valid-path model.
module tb_mat_mul_sched;

  localparam int N       = 8;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 4;

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [TAG_W-1:0] cmd_tag;
  logic             mm_cen;
  logic             mm_valid_in;
  logic             mm_mode;
  logic             mm_valid_out;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic             res_mode;
  logic             idle;
  logic             err;

  logic             force_vo;
  logic [MUL_LAT-1:0] m_pipe;
  logic             a_d;

  int n_checks = 0;
  int n_pass   = 0;

  mat_mul_sched #(
    .N     (N),
    .TAG_W (TAG_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_tag      (cmd_tag),
    .mm_cen       (mm_cen),
    .mm_valid_in  (mm_valid_in),
    .mm_mode      (mm_mode),
    .mm_valid_out (mm_valid_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_tag      (res_tag),
    .res_mode     (res_mode),
    .idle         (idle),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mat_mul valid path: MUL_LAT-deep for multiplies, one stage for adds, frozen when mm_cen is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pipe <= '0;
      a_d    <= 1'b0;
    end else if (mm_cen) begin
      m_pipe <= {m_pipe[MUL_LAT-2:0], mm_valid_in & ~mm_mode};
      a_d    <= mm_valid_in & mm_mode;
    end
  end
  assign mm_valid_out = m_pipe[MUL_LAT-1] | a_d | force_vo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic m, input logic [TAG_W-1:0] t);
    cmd_valid = v;
    cmd_mode  = m;
    cmd_tag   = t;
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = 1'b0;
    cmd_tag   = '0;
    res_ready = 1'b1;
    force_vo  = 1'b0;

    // Reset values, with a command offered to show mm_valid_in stays low.
    tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_idle", idle, 1);
    check("rst_mm_valid_in", mm_valid_in, 0);
    check("rst_mm_cen", mm_cen, 1);
    check("rst_err", err, 0);
    offer(1'b0, 1'b0, 4'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Single multiply, tag 3: result after exactly 4 edges.
    offer(1'b1, 1'b0, 4'd3);
    check("mul_ready", cmd_ready, 1);
    check("mul_valid_in", mm_valid_in, 1);
    check("mul_mm_mode", mm_mode, 0);
    tick();
    offer(1'b0, 1'b0, 4'd0);
    check("mul_busy", idle, 0);
    for (int e = 1; e <= 3; e++) begin
      check("mul_early", res_valid, 0);
      tick();
    end
    check("mul_res_valid", res_valid, 1);
    check("mul_res_tag", res_tag, 3);
    check("mul_res_mode", res_mode, 0);
    tick();
    check("mul_done_valid", res_valid, 0);
    check("mul_done_idle", idle, 1);

    // Back-to-back adds, tags 1..3: consecutive in-order results, never stalled.
    offer(1'b1, 1'b1, 4'd1);
    check("add1_ready", cmd_ready, 1);
    tick();
    check("add1_res_valid", res_valid, 1);
    check("add1_res_tag", res_tag, 1);
    check("add1_res_mode", res_mode, 1);
    offer(1'b1, 1'b1, 4'd2);
    check("add2_ready", cmd_ready, 1);
    tick();
    check("add2_res_tag", res_tag, 2);
    offer(1'b1, 1'b1, 4'd3);
    check("add3_ready", cmd_ready, 1);
    tick();
    check("add3_res_valid", res_valid, 1);
    check("add3_res_tag", res_tag, 3);
    offer(1'b0, 1'b0, 4'd0);
    tick();
    check("adds_done_valid", res_valid, 0);
    check("adds_done_idle", idle, 1);

    // Mul tag 5, then add tag 6 offered three edges later: one-cycle stall.
    offer(1'b1, 1'b0, 4'd5);
    tick();
    offer(1'b0, 1'b0, 4'd0);
    tick();
    tick();
    offer(1'b1, 1'b1, 4'd6);
    check("coll_stall", cmd_ready, 0);
    check("coll_no_fire", mm_valid_in, 0);
    tick();
    check("coll_mul_valid", res_valid, 1);
    check("coll_mul_tag", res_tag, 5);
    check("coll_mul_mode", res_mode, 0);
    check("coll_add_ready", cmd_ready, 1);
    tick();
    offer(1'b0, 1'b0, 4'd0);
    check("coll_add_valid", res_valid, 1);
    check("coll_add_tag", res_tag, 6);
    check("coll_add_mode", res_mode, 1);
    tick();
    check("coll_done_valid", res_valid, 0);
    check("coll_done_idle", idle, 1);

    // Mul tag 7 with res_ready low: pipeline freezes, result held, then drained once.
    res_ready = 1'b0;
    offer(1'b1, 1'b0, 4'd7);
    tick();
    offer(1'b0, 1'b0, 4'd0);
    tick();
    tick();
    tick();
    check("bp_res_valid", res_valid, 1);
    check("bp_res_tag", res_tag, 7);
    offer(1'b1, 1'b0, 4'd9);
    check("bp_cen", mm_cen, 0);
    check("bp_ready", cmd_ready, 0);
    check("bp_no_fire", mm_valid_in, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_tag", res_tag, 7);
      check("bp_hold_cen", mm_cen, 0);
    end
    offer(1'b0, 1'b0, 4'd0);
    res_ready = 1'b1;
    #1;
    check("bp_release_cen", mm_cen, 1);
    tick();
    check("bp_done_valid", res_valid, 0);
    check("bp_done_idle", idle, 1);
    check("bp_err", err, 0);

    // Two muls in flight, reset pulse: everything discarded.
    offer(1'b1, 1'b0, 4'd1);
    tick();
    offer(1'b1, 1'b0, 4'd2);
    check("mm_ready", cmd_ready, 1);
    tick();
    offer(1'b0, 1'b0, 4'd0);
    check("mr_busy", idle, 0);
    rstn = 1'b0;
    #1;
    check("mr_res_valid", res_valid, 0);
    check("mr_idle", idle, 1);
    check("mr_err", err, 0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mr_no_stale", res_valid, 0);
    end
    check("mr_idle_after", idle, 1);

    // Forced mm_valid_out with an empty tracker: sticky err until reset.
    force_vo = 1'b1;
    tick();
    check("err_set", err, 1);
    force_vo = 1'b0;
    tick();
    tick();
    tick();
    check("err_sticky", err, 1);
    rstn = 1'b0;
    #1;
    check("err_cleared", err, 0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("err_stays_clear", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
